// File: rtl/hca_pkg.sv
// hca_pkg: shared types and helpers for the pipelined Han-Carlson adder.
// Holds the generate/propagate pair, its prefix operator and sizing functions.
package hca_pkg;

  localparam int MAX_WIDTH = 64;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
    gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

  function automatic int hca_levels(input int width);
    return $clog2(width) + 1;
  endfunction

  function automatic int popcount(input logic [31:0] mask, input int n);
    int c;
    c = 0;
    for (int i = 0; i < n; i++) begin
      c += int'(mask[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/hca_prefix_level.sv
// hca_prefix_level: one combinational level of the Han-Carlson network.
// Bits of the selected parity at or above DIST merge with bit i-DIST.
module hca_prefix_level
  import hca_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIST  = 1,
  parameter bit ODD   = 1'b1
) (
  input  gp_t [WIDTH-1:0] i_gp,
  output gp_t [WIDTH-1:0] o_gp
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if ((((i % 2) == 1) == ODD) && (i >= DIST)) begin : g_op
      assign o_gp[i] = gp_combine(i_gp[i], i_gp[i-DIST]);
    end else begin : g_pass
      assign o_gp[i] = i_gp[i];
    end
  end

endmodule

// File: rtl/hca_pipe_adder.sv
// hca_pipe_adder: pipelined Han-Carlson add/sub with valid/ready handshake.
// Define HCA_PIPE_FLAGS_EN to add registered out_zero/out_neg flags.
module hca_pipe_adder
  import hca_pkg::*;
#(
  parameter int          WIDTH     = 16,
  parameter logic [31:0] PIPE_MASK = 32'h5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
`ifdef HCA_PIPE_FLAGS_EN
  output logic             out_zero,
  output logic             out_neg,
`endif
  output logic             out_ovf
);

  localparam int LEVELS = hca_levels(WIDTH);
  localparam int NS     = LEVELS + 1;

  logic [WIDTH-1:0] w_y;
  logic             w_c0;
  gp_t [WIDTH-1:0]  w_gp0;
  // occupancy per slot; unregistered levels count as full
  logic [NS:1]      w_full;

  always_comb begin
    w_gp0 = '0;
    w_y   = in_sub ? ~in_b : in_b;
    w_c0  = in_sub ? ~in_cin : in_cin;
    for (int i = 0; i < WIDTH; i++) begin
      w_gp0[i].g = in_a[i] & w_y[i];
      w_gp0[i].p = in_a[i] ^ w_y[i];
    end
  end

  assign in_ready = out_ready | ~&w_full;

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int DIST = (k == LEVELS) ? 1 : (1 << (k - 1));
    localparam bit ODD  = (k != LEVELS);

    gp_t [WIDTH-1:0]  w_gp_i;
    gp_t [WIDTH-1:0]  w_gp_n;
    gp_t [WIDTH-1:0]  w_gp_o;
    logic [WIDTH-1:0] w_p0_i;
    logic [WIDTH-1:0] w_p0_o;
    logic             w_c0_i;
    logic             w_c0_o;
    logic             w_v_i;
    logic             w_v_o;

    if (k == 1) begin : g_src
      assign w_gp_i = w_gp0;
      assign w_p0_i = in_a ^ w_y;
      assign w_c0_i = w_c0;
      assign w_v_i  = in_valid;
    end else begin : g_src
      assign w_gp_i = g_lvl[k-1].w_gp_o;
      assign w_p0_i = g_lvl[k-1].w_p0_o;
      assign w_c0_i = g_lvl[k-1].w_c0_o;
      assign w_v_i  = g_lvl[k-1].w_v_o;
    end

    hca_prefix_level #(
      .WIDTH (WIDTH),
      .DIST  (DIST),
      .ODD   (ODD)
    ) u_lvl (
      .i_gp (w_gp_i),
      .o_gp (w_gp_n)
    );

    if (PIPE_MASK[k-1]) begin : g_reg
      logic             w_rdy;
      logic             r_v;
      gp_t [WIDTH-1:0]  r_gp;
      logic [WIDTH-1:0] r_p0;
      logic             r_c0;

      assign w_rdy = out_ready | ~&w_full[NS:k];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_v  <= 1'b0;
          r_gp <= '0;
          r_p0 <= '0;
          r_c0 <= 1'b0;
        end else if (w_rdy) begin
          r_v <= w_v_i;
          if (w_v_i) begin
            r_gp <= w_gp_n;
            r_p0 <= w_p0_i;
            r_c0 <= w_c0_i;
          end
        end
      end

      assign w_full[k] = r_v;
      assign w_v_o     = r_v;
      assign w_gp_o    = r_gp;
      assign w_p0_o    = r_p0;
      assign w_c0_o    = r_c0;
    end else begin : g_pass
      assign w_full[k] = 1'b1;
      assign w_v_o     = w_v_i;
      assign w_gp_o    = w_gp_n;
      assign w_p0_o    = w_p0_i;
      assign w_c0_o    = w_c0_i;
    end
  end

  gp_t [WIDTH-1:0]  w_gpf;
  logic [WIDTH-1:0] w_p0f;
  logic             w_c0f;
  logic             w_vf;
  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_sum;
  logic             w_rdy_o;

  assign w_gpf = g_lvl[LEVELS].w_gp_o;
  assign w_p0f = g_lvl[LEVELS].w_p0_o;
  assign w_c0f = g_lvl[LEVELS].w_c0_o;
  assign w_vf  = g_lvl[LEVELS].w_v_o;

  // every bit now holds its group term down to bit 0
  always_comb begin
    w_c    = '0;
    w_c[0] = w_c0f;
    for (int i = 0; i < WIDTH; i++) begin
      w_c[i+1] = w_gpf[i].g | (w_gpf[i].p & w_c0f);
    end
  end

  assign w_sum = w_p0f ^ w_c[WIDTH-1:0];

  logic             r_out_v;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
`ifdef HCA_PIPE_FLAGS_EN
  logic             r_zero;
  logic             r_neg;
`endif

  assign w_rdy_o    = out_ready | ~r_out_v;
  assign w_full[NS] = r_out_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_v <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
`ifdef HCA_PIPE_FLAGS_EN
      r_zero  <= 1'b0;
      r_neg   <= 1'b0;
`endif
    end else if (w_rdy_o) begin
      r_out_v <= w_vf;
      if (w_vf) begin
        r_sum  <= w_sum;
        r_cout <= w_c[WIDTH];
        r_ovf  <= w_c[WIDTH-1] ^ w_c[WIDTH];
`ifdef HCA_PIPE_FLAGS_EN
        r_zero <= ~|w_sum;
        r_neg  <= w_sum[WIDTH-1];
`endif
      end
    end
  end

  assign out_valid = r_out_v;
  assign out_sum   = r_sum;
  assign out_cout  = r_cout;
  assign out_ovf   = r_ovf;
`ifdef HCA_PIPE_FLAGS_EN
  assign out_zero  = r_zero;
  assign out_neg   = r_neg;
`endif

endmodule

// File: doc/hca_pipe_adder.md
Name: hca_pipe_adder

Overview:
- Parametrised, pipelined Han-Carlson prefix adder/subtractor.
- Generalises the fixed 16-bit combinational Han-Carlson adder in three ways: any power-of-two width, add or subtract selected per transaction, and pipeline registers selectable per prefix level.
- Sits between datapath stages with a valid/ready handshake; sustains one operation per cycle under full throughput.

Parameters:
- WIDTH, 16, operand width; power of two, 4..64.
- PIPE_MASK, 32'h5, bit k=1 inserts a register after prefix level k+1; only the low LEVELS bits are used, where LEVELS = log2(WIDTH)+1.
- The output register is always present.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand transaction valid
- in_ready  out  1  adder can accept a transaction
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_cin  in  1  carry-in when adding; borrow-in when subtracting
- in_sub  in  1  0 = A+B+cin; 1 = A-B-borrow
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_sum  out  WIDTH  sum/difference
- out_cout  out  1  raw carry-out (in subtract mode 1 = no borrow)
- out_ovf  out  1  two's-complement overflow

Behaviour:
- Reset: one clock, clk. rst_n is asynchronous and active-low; asserting it clears every stage valid and data register. out_valid=0, out_sum=0, out_cout=0, out_ovf=0. in_ready=1 once rst_n deasserts.
- Pre-processing (stage 0, combinational at input):
  - Y = in_sub ? ~in_b : in_b
  - c0 = in_sub ? ~in_cin : in_cin
  - G = A&Y, P = A^Y
- Prefix network:
  - Level 1: odd bits i combine with i-1.
  - Levels 2..log2(WIDTH): Kogge-Stone on odd bits, distances 2, 4, ..., WIDTH/2.
  - Level LEVELS: even bits i>0 combine with i-1.
  - Operator: (G,P)o(G',P') = (G|P&G', P&P').
  - Carry into bit i+1 = Gi:0 | Pi:0&c0.
- Output terms:
  - sum[i] = P[i] ^ carry_in_i
  - out_cout = carry out of bit WIDTH-1
  - out_ovf = carry into MSB XOR out_cout
- Pipeline: stages are the PIPE_MASK-selected level registers plus the output register. Each stage carries a valid bit with the partial G/P/P0/c0 it needs. Latency = popcount(PIPE_MASK[LEVELS-1:0])+1 cycles from input handshake to out_valid.
- Handshake:
  - Input transfer on in_valid&in_ready; output transfer on out_valid&out_ready.
  - stage_ready[k] = !stage_valid[k] | stage_ready[k+1]; last stage uses out_ready. in_ready = stage_ready[0].
  - A stalled stage holds its data and valid. out_sum, out_cout and out_ovf are stable while out_valid&!out_ready.
  - Simultaneous accept and emit at a full pipeline with out_ready=1 sustains throughput 1/cycle.
  - Transactions are never dropped, duplicated or reordered.
- Boundaries:
  - WIDTH=4 gives LEVELS=3.
  - PIPE_MASK=0 gives latency 1.
  - All ones gives latency LEVELS+1.
  - Inputs are ignored when in_valid=0, and no bubble propagates as valid.
  - Reset mid-stream discards all in-flight transactions immediately.

Optional Feature:
- Macro: HCA_PIPE_FLAGS_EN
- Defined: adds ports out_zero (out_sum==0) and out_neg (out_sum[WIDTH-1]), both 1 bit, registered alongside out_sum, reset 0, same stall behaviour.
- Undefined: ports absent; no added logic.

Decomposition:
- Package hca_pkg:
  - typedef gp_t {g,p}
  - function hca_levels(width)
  - function popcount for latency
  - constant MAX_WIDTH=64
- Sub-module hca_prefix_level:
  - One combinational prefix level, parameterised by WIDTH, distance and odd/even selection.
  - Instantiated in a generate loop; an optional register slice follows it per PIPE_MASK bit.

Test Plan:
- WIDTH=16, PIPE_MASK=5, in_a=16'hFFFF, in_b=16'h0001, in_cin=0, add -> after 3 cycles: out_sum=16'h0000, out_cout=1, out_ovf=0.
- in_a=16'h8000, in_b=16'h0001, in_sub=1, in_cin=0 -> out_sum=16'h7FFF, out_cout=1, out_ovf=1. Also in_a=16'h0000, in_b=16'h0001, sub -> out_sum=16'hFFFF, out_cout=0.
- 1000 back-to-back random vectors with mixed add/sub and cin, out_ready=1 -> one result per cycle, latency exactly 3, each matching a golden A±B±c.
- Fill the pipeline, then hold out_ready=0 for 6 cycles -> outputs frozen, in_ready=0 after 3 accepted, no loss or duplication after release. Random out_ready toggling over 500 transactions -> scoreboard clean.
- rst_n pulled low with 3 in flight -> out_valid=0 asynchronously. After release, in_ready=1 and no stale result emerges.
- Parameter sweep WIDTH=4 exhaustive, WIDTH=8 PIPE_MASK=0 (latency 1), WIDTH=64 PIPE_MASK=7'h7F (latency 8) random. With HCA_PIPE_FLAGS_EN defined: 5-5 -> out_zero=1; 3-5 -> out_neg=1.
